// File: rtl/rsa_pkg.sv
// Shared constants and encodings for the small-operand RSA datapath.
// The reducer depth assumes operands below N, so RED_STEPS = W + 1.
package rsa_pkg;
    localparam int W         = 6;
    localparam int EW        = 6;
    localparam int RED_STEPS = 7;

    typedef enum logic [1:0] {IDLE, MUL, RED, DONE} state_e;
    typedef enum logic [1:0] {INIT, SQR, MULT} op_e;
endpackage

// File: rtl/mod_reduce.sv
// Restoring shift-subtract reducer: walks k = RED_STEPS-1 .. 0, subtracting N<<k when it fits.
// rem shows the remainder after the current step, so the caller can write back on the last step.
module mod_reduce
    import rsa_pkg::*;
#(
    parameter int W = rsa_pkg::W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [2*W-1:0] p_in,
    input  logic [W-1:0]   n_in,
    input  logic           step,
    output logic           last,
    output logic [W-1:0]   rem
);
    localparam int KW = $clog2(RED_STEPS);

    logic [2*W-1:0] p_q, p_d;
    logic [W-1:0]   n_q, n_d;
    logic [KW-1:0]  k_q, k_d;
    logic [2*W:0]   n_sh, p_sub;

    always_comb begin
        n_sh  = {{(W+1){1'b0}}, n_q} << k_q;
        // Borrow out of the extra top bit means N<<k does not fit.
        p_sub = {1'b0, p_q} - n_sh;
        p_d   = p_q;
        n_d   = n_q;
        k_d   = k_q;
        if (load) begin
            p_d = p_in;
            n_d = n_in;
            k_d = KW'(RED_STEPS - 1);
        end else if (step) begin
            if (!p_sub[2*W]) p_d = p_sub[2*W-1:0];
            k_d = k_q - 1'b1;
        end
    end

    assign last = (k_q == '0);
    assign rem  = p_d[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            n_q <= '0;
            k_q <= '0;
        end else begin
            p_q <= p_d;
            n_q <= n_d;
            k_q <= k_d;
        end
    end
endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply controller time-sharing one external W x W multiplier.
// Each op is one MUL cycle followed by RED_STEPS reduction cycles.
module modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int W  = rsa_pkg::W,
    parameter int EW = rsa_pkg::EW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   base,
    input  logic [EW-1:0]  exp,
    input  logic [W-1:0]   modulus,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [W-1:0]   result,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [2*W-1:0] mul_p
);
    localparam int BW = (EW > 1) ? $clog2(EW) : 1;

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [W-1:0]  n_q, n_d, r_q, r_d, m_q, m_d, result_q, result_d;
    logic [W-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic          red_last, fin;
    logic [W-1:0]  red_rem;

    mod_reduce #(.W(W)) u_red (
        .clk  (clk),
        .rst  (rst),
        .load (state_q == MUL),
        .p_in (mul_p),
        .n_in (n_q),
        .step (state_q == RED),
        .last (red_last),
        .rem  (red_rem)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        bit_d    = bit_q;
        exp_d    = exp_q;
        n_d      = n_q;
        r_d      = r_q;
        m_d      = m_q;
        result_d = result_q;
        err_d    = err_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        mul_a_d  = '0;
        mul_b_d  = '0;
        fin      = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                exp_d = exp;
                n_d   = modulus;
                r_d   = W'(1);
                err_d = (modulus == '0);
                if (modulus == '0) begin
                    state_d  = DONE;
                    result_d = '0;
                    done_d   = 1'b1;
                end else begin
                    state_d = MUL;
                    op_d    = INIT;
                    bit_d   = BW'(EW - 1);
                    busy_d  = 1'b1;
                    mul_a_d = base;
                    mul_b_d = W'(1);
                end
            end
            MUL: begin
                state_d = RED;
                busy_d  = 1'b1;
            end
            RED: begin
                busy_d = 1'b1;
                if (red_last) begin
                    case (op_q)
                        INIT: begin
                            m_d  = red_rem;
                            op_d = SQR;
                        end
                        SQR: begin
                            r_d = red_rem;
                            if (exp_q[bit_q]) op_d = MULT;
                            else if (bit_q == '0) fin = 1'b1;
                            else bit_d = bit_q - 1'b1;
                        end
                        default: begin
                            r_d = red_rem;
                            if (bit_q == '0) fin = 1'b1;
                            else begin
                                op_d  = SQR;
                                bit_d = bit_q - 1'b1;
                            end
                        end
                    endcase
                    if (fin) begin
                        state_d  = DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        result_d = r_d;
                    end else begin
                        // Operands come from the value being written back this edge.
                        state_d = MUL;
                        mul_a_d = r_d;
                        mul_b_d = (op_d == MULT) ? m_d : r_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= INIT;
            bit_q    <= '0;
            exp_q    <= '0;
            n_q      <= '0;
            r_q      <= '0;
            m_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            bit_q    <= bit_d;
            exp_q    <= exp_d;
            n_q      <= n_d;
            r_q      <= r_d;
            m_q      <= m_d;
            result_q <= result_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;
endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: directed vectors plus a random sweep against a pow-mod model.
module tb_modexp_ctrl;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [5:0]  base, exp, modulus;
    logic        busy, done, err;
    logic [5:0]  result, mul_a, mul_b;
    logic [11:0] mul_p;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign mul_p = {6'b0, mul_a} * {6'b0, mul_b};

    modexp_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .exp(exp), .modulus(modulus),
        .busy(busy), .done(done), .err(err), .result(result),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
    );

    function automatic int powmod(input int b, input int e, input int n);
        int r;
        if (n == 0) return 0;
        r = 1 % n;
        for (int i = 0; i < e; i++) r = (r * b) % n;
        return r;
    endfunction

    function automatic int exp_lat(input logic [5:0] e, input int n);
        if (n == 0) return 1;
        return 8 * (1 + 6 + $countones(e)) + 1;
    endfunction

    // Starts an op (cycle 0 = accept cycle), pulses start again at p1/p2, and
    // returns one cycle after done. Busy/mul/stability violations are tallied.
    task automatic run_op(input logic [5:0] b, input logic [5:0] e, input logic [5:0] n,
                          input int p1, input int p2,
                          output int done_cyc, output int res, output int er,
                          output int bad_busy, output int bad_mul, output int done_cnt);
        int k8;
        bit bz, in_mul;
        k8 = (n == 0) ? 0 : exp_lat(e, n) - 1;
        done_cyc = -1; res = -1; er = -1;
        bad_busy = 0; bad_mul = 0; done_cnt = 0;
        @(posedge clk); #1;
        base = b; exp = e; modulus = n; start = 1'b1;
        for (int c = 1; c <= 140; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            base = 6'($urandom); exp = 6'($urandom); modulus = 6'($urandom);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c; res = int'(result); er = int'(err);
                end
            end
            bz = (c <= k8);
            in_mul = bz && ((c - 1) % 8 == 0);
            if (busy !== bz) bad_busy++;
            if (!in_mul && (mul_a !== 6'd0 || mul_b !== 6'd0)) bad_mul++;
            if (done_cyc > 0 && c == done_cyc + 1) begin
                if (int'(result) != res || int'(err) != er) bad_busy++;
                break;
            end
            if (c == p1 || c == p2) start = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base = '0; exp = '0; modulus = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, err, result, mul_a, mul_b} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero", {busy, done, err, result, mul_a, mul_b});
        end
    endtask

    task automatic test_vectors();
        logic [5:0] tb_b [5] = '{6'd4, 6'd5, 6'd63, 6'd47, 6'd9};
        logic [5:0] tb_e [5] = '{6'd13, 6'd0, 6'd63, 6'd29, 6'd5};
        logic [5:0] tb_n [5] = '{6'd33, 6'd7, 6'd61, 6'd1, 6'd0};
        int dc, rs, er, bb, bm, dn;
        for (int i = 0; i < 5; i++) begin
            run_op(tb_b[i], tb_e[i], tb_n[i], -1, -1, dc, rs, er, bb, bm, dn);
            checks += 5;
            if (rs != powmod(tb_b[i], tb_e[i], tb_n[i])) begin
                errors++; $display("FAIL vec%0d_result: got %0d expected %0d", i, rs, powmod(tb_b[i], tb_e[i], tb_n[i]));
            end
            if (dc != exp_lat(tb_e[i], tb_n[i])) begin
                errors++; $display("FAIL vec%0d_latency: got %0d expected %0d", i, dc, exp_lat(tb_e[i], tb_n[i]));
            end
            if (er != int'(tb_n[i] == 0)) begin
                errors++; $display("FAIL vec%0d_err: got %0d expected %0d", i, er, int'(tb_n[i] == 0));
            end
            if (bb != 0 || dn != 1) begin
                errors++; $display("FAIL vec%0d_busy_done: got %0d busy errs, %0d dones expected 0, 1", i, bb, dn);
            end
            if (bm != 0) begin
                errors++; $display("FAIL vec%0d_mul_idle: got %0d nonzero cycles expected 0", i, bm);
            end
        end
    endtask

    task automatic test_start_ignored();
        int dc, rs, er, bb, bm, dn;
        run_op(6'd4, 6'd13, 6'd33, 10, 40, dc, rs, er, bb, bm, dn);
        checks += 3;
        if (dn != 1 || dc != 81) begin
            errors++; $display("FAIL ignore_done: got %0d dones at %0d expected 1 at 81", dn, dc);
        end
        if (rs != 31) begin
            errors++; $display("FAIL ignore_result: got %0d expected 31", rs);
        end
        if (bb != 0) begin
            errors++; $display("FAIL ignore_busy: got %0d busy errs expected 0", bb);
        end
    endtask

    task automatic test_midrun_reset();
        int dc, rs, er, bb, bm, dn;
        @(posedge clk); #1;
        base = 6'd4; exp = 6'd13; modulus = 6'd33; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, err, result, mul_a, mul_b} !== 21'd0) begin
            errors++;
            $display("FAIL midrun_reset: got %b expected all zero", {busy, done, err, result, mul_a, mul_b});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(6'd4, 6'd13, 6'd33, -1, -1, dc, rs, er, bb, bm, dn);
        checks += 2;
        if (rs != 31 || dc != 81) begin
            errors++; $display("FAIL post_reset_run: got %0d at %0d expected 31 at 81", rs, dc);
        end
        if (bb != 0 || bm != 0 || dn != 1) begin
            errors++; $display("FAIL post_reset_seq: got %0d/%0d/%0d expected 0/0/1", bb, bm, dn);
        end
    endtask

    task automatic test_random();
        int dc, rs, er, bb, bm, dn, ref_r, ref_l;
        logic [5:0] b, e, n;
        for (int t = 0; t < 300; t++) begin
            b = 6'($urandom_range(0, 63));
            e = 6'($urandom_range(0, 63));
            n = 6'($urandom_range(1, 63));
            ref_r = powmod(b, e, n);
            ref_l = exp_lat(e, n);
            run_op(b, e, n, -1, -1, dc, rs, er, bb, bm, dn);
            checks += 4;
            if (rs != ref_r) begin
                errors++; $display("FAIL rnd_result b=%0d e=%0d n=%0d: got %0d expected %0d", b, e, n, rs, ref_r);
            end
            if (dc != ref_l) begin
                errors++; $display("FAIL rnd_latency e=%0d: got %0d expected %0d", e, dc, ref_l);
            end
            if (bb != 0 || er != 0 || dn != 1) begin
                errors++; $display("FAIL rnd_seq: got busy errs %0d err %0d dones %0d expected 0 0 1", bb, er, dn);
            end
            if (bm != 0) begin
                errors++; $display("FAIL rnd_mul_idle: got %0d nonzero cycles expected 0", bm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_start_ignored();
        test_midrun_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
